// File: rtl/confetti_animator_pkg.sv
// rtl/confetti_animator_pkg.sv - shared confetti table types, state encoding and position helper
package confetti_animator_pkg;

    localparam int          CONFETTI_NUM      = 101;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef struct packed {
        logic [31:0] rowstart;
        logic [31:0] colstart;
        logic [31:0] width;
        logic [31:0] length;
    } confetti_struct;

    typedef enum logic [1:0] {IDLE, SEED, RUN, DRAIN} anim_state_t;

    // Keeps the low `bits` of the LFSR and folds them into [0, lim) with one subtract.
    function automatic logic [31:0] wrap_pos(input logic [15:0] lfsr, input int bits, input int lim);
        logic [31:0] v;
        v = 32'(lfsr) & ((32'd1 << bits) - 32'd1);
        return (v < 32'(lim)) ? v : v - 32'(lim);
    endfunction

endpackage

// File: rtl/confetti_animator_if.sv
// rtl/confetti_animator_if.sv - control pulses and confetti table bundle
interface confetti_animator_if
    import confetti_animator_pkg::*;
#(
    parameter int NUM = CONFETTI_NUM
);
    logic                     start;
    logic                     stop;
    logic                     frame_tick;
    confetti_struct [NUM-1:0] confetti_array;
    logic                     active;
    logic                     busy;

    modport master (
        output start, stop, frame_tick,
        input  confetti_array, active, busy
    );

    modport slave (
        input  start, stop, frame_tick,
        output confetti_array, active, busy
    );
endinterface

// File: rtl/confetti_lfsr16.sv
// rtl/confetti_lfsr16.sv - 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, free-running
module confetti_lfsr16
    import confetti_animator_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign out  = r_lfsr;

    // An all-zero state would lock up, so a zero seed falls back to the default.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end
endmodule

// File: rtl/confetti_animator.sv
// rtl/confetti_animator.sv - seeds, drops, respawns and drains the confetti table one entry per clock
module confetti_animator
    import confetti_animator_pkg::*;
#(
    parameter int          NUM       = CONFETTI_NUM,
    parameter int          ROWS      = 480,
    parameter int          COLS      = 640,
    parameter int          SIZE      = 5,
    parameter int          FALL_STEP = 2,
    parameter logic [15:0] SEED      = LFSR_DEFAULT_SEED
)(
    input  logic               clk,
    input  logic               reset,
    confetti_animator_if.slave bus
);
    localparam int            IW        = $clog2(NUM);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NUM - 1);
    localparam logic [32:0]   ROW_LIMIT = 33'(ROWS - SIZE);

    anim_state_t              r_state;
    logic [IW-1:0]            r_idx;
    logic                     r_sweep;
    logic                     r_stop_pend;
    logic                     r_any_live;
    logic                     r_active;
    logic                     r_busy;
    confetti_struct [NUM-1:0] r_table;

    logic [15:0]              w_lfsr;
    confetti_struct           w_cur;
    confetti_struct           w_seed_entry;
    confetti_struct           w_next;
    logic [32:0]              w_sum;
    logic                     w_next_live;

    confetti_lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED),
        .out   (w_lfsr)
    );

    assign bus.confetti_array = r_table;
    assign bus.active         = r_active;
    assign bus.busy           = r_busy;

    // Next value of the entry under the sweep pointer; the 33-bit sum keeps the bound compare wrap-free.
    always_comb begin
        w_cur                 = r_table[r_idx];
        w_sum                 = {1'b0, w_cur.rowstart} + 33'(FALL_STEP);
        w_seed_entry.rowstart = wrap_pos(w_lfsr, 9, ROWS - SIZE);
        w_seed_entry.colstart = wrap_pos(w_lfsr, 10, COLS - SIZE);
        w_seed_entry.width    = 32'(SIZE);
        w_seed_entry.length   = 32'(SIZE);
        w_next                = w_cur;
        if (w_cur.width != 32'd0) begin
            if (w_sum <= ROW_LIMIT) begin
                w_next.rowstart = w_sum[31:0];
            end else if (r_state == RUN) begin
                w_next          = w_seed_entry;
                w_next.rowstart = 32'd0;
            end else begin
                w_next = '0;
            end
        end
        w_next_live = (w_next.width != 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_sweep     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_any_live  <= 1'b0;
            r_active    <= 1'b0;
            r_busy      <= 1'b0;
            r_table     <= '0;
        end else if (bus.start) begin
            r_state     <= confetti_animator_pkg::SEED;
            r_idx       <= '0;
            r_sweep     <= 1'b0;
            r_stop_pend <= 1'b0;
            r_active    <= 1'b0;
            r_busy      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                end
                confetti_animator_pkg::SEED: begin
                    r_table[r_idx] <= w_seed_entry;
                    if (bus.stop) r_stop_pend <= 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_idx    <= '0;
                        r_busy   <= 1'b0;
                        r_active <= 1'b1;
                        r_state  <= (r_stop_pend || bus.stop) ? DRAIN : RUN;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    if (bus.stop && r_state == RUN) r_state <= DRAIN;
                    // frame_tick is only honoured between sweeps; ticks arriving mid-sweep are dropped.
                    if (!r_sweep) begin
                        if (bus.frame_tick) begin
                            r_sweep    <= 1'b1;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                            r_any_live <= 1'b0;
                        end
                    end else begin
                        r_table[r_idx] <= w_next;
                        if (r_idx == LAST_IDX) begin
                            r_sweep <= 1'b0;
                            r_busy  <= 1'b0;
                            r_idx   <= '0;
                            if (r_state == DRAIN && !(r_any_live || w_next_live)) begin
                                r_state  <= IDLE;
                                r_active <= 1'b0;
                            end
                        end else begin
                            r_idx      <= r_idx + 1'b1;
                            r_any_live <= r_any_live | w_next_live;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
